// File: rtl/fpmul_pipe.sv
// Pipelined binary floating-point multiplier (DAZ/FTZ, canonical NaN, sticky flags).
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fpmul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_a,
  input  logic [EXP_W+MAN_W:0]   i_b,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [EXP_W+MAN_W:0]   o_res,
  output logic                   o_flag_ovf,
  output logic                   o_flag_unf,
  output logic                   o_flag_inv,
  input  logic                   i_flags_clr
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam int EMAX = (2 ** EXP_W) - 1;

  // Handshake: an operand pair moves in on a rising edge when i_valid & o_ready,
  // a result moves out when o_valid & i_ready; the whole pipe stalls as one unit.
  logic w_adv;
  logic w_xfer;

  // ---------------- S1: decode, classify, sign, exponent sum ----------------
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic             w_sign, w_inv, w_nan, w_special;
  logic [W-1:0]     w_spec_res;
  logic [EW-1:0]    w_esum;

  assign w_ea = i_a[W-2:MAN_W];
  assign w_eb = i_b[W-2:MAN_W];
  assign w_fa = i_a[MAN_W-1:0];
  assign w_fb = i_b[MAN_W-1:0];

  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) & (w_fa == '0);
  assign w_b_inf  = (&w_eb) & (w_fb == '0);
  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);

  assign w_sign    = i_a[W-1] ^ i_b[W-1];
  assign w_inv     = (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_nan     = w_a_nan | w_b_nan | w_inv;
  assign w_special = w_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_esum    = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);

  always_comb begin
    w_spec_res = '0;
    if (w_nan) begin
      w_spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (w_a_inf | w_b_inf) begin
      w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      w_spec_res = {w_sign, {(W-1){1'b0}}};
    end
  end

  logic             r_s1_valid;
  logic             r_s1_special;
  logic [W-1:0]     r_s1_spec_res;
  logic             r_s1_inv;
  logic             r_s1_sign;
  logic [EW-1:0]    r_s1_esum;
  logic [MAN_W:0]   r_s1_ma, r_s1_mb;

  // ---------------- S2: significand product ----------------
  logic             r_s2_valid;
  logic             r_s2_special;
  logic [W-1:0]     r_s2_spec_res;
  logic             r_s2_inv;
  logic             r_s2_sign;
  logic [EW-1:0]    r_s2_esum;
  logic [PW-1:0]    r_s2_prod;

  // ---------------- S3: normalise, round, range check, encode ----------------
  logic             w_n;
  logic [PW-1:0]    w_pn;
  logic [MAN_W-1:0] w_frac;
  logic             w_inc;
  logic [MAN_W:0]   w_frac_rnd;
  logic [EW-1:0]    w_exp;
  logic             w_ovf, w_unf;
  logic [W-1:0]     w_s3_res;
  logic             w_ovf_ev, w_unf_ev, w_inv_ev;

  // After normalisation the leading one sits at PW-1; guard is bit MAN_W.
  assign w_n    = r_s2_prod[PW-1];
  assign w_pn   = w_n ? r_s2_prod : {r_s2_prod[PW-2:0], 1'b0};
  assign w_frac = w_pn[PW-2 -: MAN_W];

`ifdef FPMUL_RNE_EN
  logic w_guard, w_sticky;
  logic w_unused;
  assign w_guard  = w_pn[MAN_W];
  assign w_sticky = |w_pn[MAN_W-1:0];
  assign w_inc    = w_guard & (w_sticky | w_frac[0]);
  assign w_unused = w_pn[PW-1];
`else
  logic w_unused;
  assign w_inc    = 1'b0;
  assign w_unused = ^{w_pn[PW-1], w_pn[MAN_W:0]};
`endif

  assign w_frac_rnd = {1'b0, w_frac} + (MAN_W+1)'(w_inc);
  assign w_exp      = r_s2_esum + EW'(w_n) + EW'(w_frac_rnd[MAN_W]);
  assign w_ovf      = !w_exp[EW-1] & (w_exp >= EW'(EMAX));
  assign w_unf      = w_exp[EW-1] | (w_exp == '0);

  always_comb begin
    w_s3_res = '0;
    if (r_s2_special) begin
      w_s3_res = r_s2_spec_res;
    end else if (w_ovf) begin
      w_s3_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_unf) begin
      w_s3_res = {r_s2_sign, {(W-1){1'b0}}};
    end else begin
      w_s3_res = {r_s2_sign, w_exp[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
    end
  end

  assign w_ovf_ev = !r_s2_special & w_ovf;
  assign w_unf_ev = !r_s2_special & !w_ovf & w_unf;
  assign w_inv_ev = r_s2_special & r_s2_inv;

  logic             r_s3_valid;
  logic [W-1:0]     r_s3_res;
  logic             r_s3_ovf, r_s3_unf, r_s3_inv;

  // ---------------- flow control ----------------
  assign w_adv   = !r_s3_valid | i_ready;
  assign w_xfer  = r_s3_valid & i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_s3_valid;
  assign o_res   = r_s3_res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_res   <= '0;
    end else if (w_adv) begin
      r_s1_valid <= i_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      r_s3_res   <= w_s3_res;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_adv) begin
      r_s1_special  <= w_special;
      r_s1_spec_res <= w_spec_res;
      r_s1_inv      <= w_inv;
      r_s1_sign     <= w_sign;
      r_s1_esum     <= w_esum;
      r_s1_ma       <= {1'b1, w_fa};
      r_s1_mb       <= {1'b1, w_fb};

      r_s2_special  <= r_s1_special;
      r_s2_spec_res <= r_s1_spec_res;
      r_s2_inv      <= r_s1_inv;
      r_s2_sign     <= r_s1_sign;
      r_s2_esum     <= r_s1_esum;
      r_s2_prod     <= PW'(r_s1_ma) * PW'(r_s1_mb);

      r_s3_ovf      <= w_ovf_ev;
      r_s3_unf      <= w_unf_ev;
      r_s3_inv      <= w_inv_ev;
    end
  end

  // A flag event lands only when its result transfers; setting beats clearing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_flag_ovf <= 1'b0;
      o_flag_unf <= 1'b0;
      o_flag_inv <= 1'b0;
    end else begin
      o_flag_ovf <= (o_flag_ovf & ~i_flags_clr) | (w_xfer & r_s3_ovf);
      o_flag_unf <= (o_flag_unf & ~i_flags_clr) | (w_xfer & r_s3_unf);
      o_flag_inv <= (o_flag_inv & ~i_flags_clr) | (w_xfer & r_s3_inv);
    end
  end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Self-checking bench for fpmul_pipe: directed test-plan cases, randomized stream with
// random backpressure against a value-level reference model, stall, flag and reset cases.
module tb_fpmul_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX  = (1 << EXP_W) - 1;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a, i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_res;
  logic         o_flag_ovf, o_flag_unf, o_flag_inv;
  logic         i_flags_clr;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [2:0]   exp_flags;   // {inv, unf, ovf}

  fpmul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_res       (o_res),
    .o_flag_ovf  (o_flag_ovf),
    .o_flag_unf  (o_flag_unf),
    .o_flag_inv  (o_flag_inv),
    .i_flags_clr (i_flags_clr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Collects every transferred result; sampled on the falling edge, inputs move after rising.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) got_q.push_back(o_res);
  end

  // ---------------- reference model ----------------
  // Returns {inv, unf, ovf, result} from real-valued rules on integer significands.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int     ea, eb, e, s;
    longint fa, fb, p, q;
    logic   sr;
    bit     za, zb, ia, ib, na, nb, inv;
`ifdef FPMUL_RNE_EN
    longint rem, half;
`endif
    ea = int'(a[W-2:MAN_W]);
    eb = int'(b[W-2:MAN_W]);
    fa = longint'(a[MAN_W-1:0]);
    fb = longint'(b[MAN_W-1:0]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == EMAX) && (fa == 0);
    ib = (eb == EMAX) && (fb == 0);
    na = (ea == EMAX) && (fa != 0);
    nb = (eb == EMAX) && (fb != 0);
    sr = a[W-1] ^ b[W-1];
    inv = (ia && zb) || (ib && za);
    if (na || nb || inv)
      return {inv, 2'b00, 1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    if (ia || ib) return {3'b000, sr, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (za || zb) return {3'b000, sr, {(W-1){1'b0}}};
    p = ((longint'(1) << MAN_W) + fa) * ((longint'(1) << MAN_W) + fb);
    s = (p >= (longint'(1) << (2 * MAN_W + 1))) ? MAN_W + 1 : MAN_W;
    q = p >> s;
`ifdef FPMUL_RNE_EN
    rem  = p - (q << s);
    half = longint'(1) << (s - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
    e = ea + eb - BIAS + (s - MAN_W);
    if (q == (longint'(1) << (MAN_W + 1))) begin
      q = longint'(1) << MAN_W;
      e = e + 1;
    end
    if (e >= EMAX) return {3'b001, sr, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (e <= 0)    return {3'b010, sr, {(W-1){1'b0}}};
    return {3'b000, sr, e[EXP_W-1:0], q[MAN_W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic             s;
    int               sel;
    sel = $urandom_range(0, 15);
    s   = 1'($urandom_range(0, 1));
    f   = MAN_W'($urandom_range(0, (1 << MAN_W) - 1));
    if (sel == 0)      e = '0;
    else if (sel == 1) e = '1;
    else if (sel < 10) e = EXP_W'($urandom_range(10, 20));
    else               e = EXP_W'($urandom_range(1, EMAX - 1));
    if (sel == 2) f = '0;
    if (sel == 3) f[MAN_W/2-1:0] = '0;
    return {s, e, f};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+2:0] m;
    int           guard;
    guard   = 0;
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    @(negedge i_clk);
    while (!o_ready && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
    end
    m = model(a, b);
    exp_q.push_back(m[W-1:0]);
    exp_flags = exp_flags | m[W+2:W];
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 400) begin
      @(posedge i_clk); #1;
      guard++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results required %0d", got_q.size(), n);
    end
  endtask

  task automatic clr_flags();
    @(posedge i_clk); #1;
    i_flags_clr = 1'b1;
    @(posedge i_clk); #1;
    i_flags_clr = 1'b0;
    exp_flags = 3'b000;
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
    exp_flags = 3'b000;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #10;
    checks++;
    if (o_valid !== 1'b0 || o_res !== '0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b res=%h ready=%b required 0 0000 1", o_valid, o_res, o_ready);
    end
    checks++;
    if ({o_flag_inv, o_flag_unf, o_flag_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: %b required 000", {o_flag_inv, o_flag_unf, o_flag_ovf});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: valid=%b ready=%b required 0 1", o_valid, o_ready);
    end
  endtask

  // The presenting edge is edge 1; the result must be visible after edge 3.
  task automatic test_latency();
    start_test();
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_a = 16'h3C00;
    i_b = 16'h3C00;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL latency_e1: o_valid=%b required 0", o_valid);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL latency_e2: o_valid=%b required 0", o_valid);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_res !== 16'h3C00) begin
      errors++; $display("FAIL latency_e3: valid=%b res=%h required 1 3c00", o_valid, o_res);
    end
    @(posedge i_clk); #1;
    checks++;
    if ({o_flag_inv, o_flag_unf, o_flag_ovf} !== 3'b000) begin
      errors++; $display("FAIL latency_flags: %b required 000", {o_flag_inv, o_flag_unf, o_flag_ovf});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[10], tb[10], tr[10];
    logic [2:0]   tf[10];
    ta[0] = 16'h3C00; tb[0] = 16'h3C00; tr[0] = 16'h3C00; tf[0] = 3'b000;
`ifdef FPMUL_RNE_EN
    ta[1] = 16'h3E00; tb[1] = 16'h3C01; tr[1] = 16'h3E02; tf[1] = 3'b000;
`else
    ta[1] = 16'h3E00; tb[1] = 16'h3C01; tr[1] = 16'h3E01; tf[1] = 3'b000;
`endif
    ta[2] = 16'h7BFF; tb[2] = 16'h4000; tr[2] = 16'h7C00; tf[2] = 3'b001;
    ta[3] = 16'h8400; tb[3] = 16'h0400; tr[3] = 16'h8000; tf[3] = 3'b010;
    ta[4] = 16'h7C00; tb[4] = 16'h0000; tr[4] = 16'h7E00; tf[4] = 3'b100;
    ta[5] = 16'h7E01; tb[5] = 16'h3C00; tr[5] = 16'h7E00; tf[5] = 3'b000;
    ta[6] = 16'h0001; tb[6] = 16'h3C00; tr[6] = 16'h0000; tf[6] = 3'b000;
    ta[7] = 16'hFC00; tb[7] = 16'h3C00; tr[7] = 16'hFC00; tf[7] = 3'b000;
    ta[8] = 16'h8000; tb[8] = 16'h4000; tr[8] = 16'h8000; tf[8] = 3'b000;
    ta[9] = 16'h4000; tb[9] = 16'hC200; tr[9] = 16'hC600; tf[9] = 3'b000;
    for (int i = 0; i < 10; i++) begin
      start_test();
      clr_flags();
      drive_op(ta[i], tb[i]);
      wait_drain(1);
      @(posedge i_clk); #1;
      checks++;
      if (got_q.size() < 1 || got_q[0] !== tr[i]) begin
        errors++;
        $display("FAIL directed_res[%0d]: %h*%h got %h required %h", i, ta[i], tb[i],
                 (got_q.size() > 0) ? got_q[0] : '0, tr[i]);
      end
      checks++;
      if ({o_flag_inv, o_flag_unf, o_flag_ovf} !== tf[i]) begin
        errors++;
        $display("FAIL directed_flags[%0d]: %b required %b", i, {o_flag_inv, o_flag_unf, o_flag_ovf}, tf[i]);
      end
    end
  endtask

  task automatic test_random();
    bit done;
    start_test();
    clr_flags();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          drive_op(rand_op(), rand_op());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge i_clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    wait_drain(exp_q.size());
    @(posedge i_clk); #1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_res[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({o_flag_inv, o_flag_unf, o_flag_ovf} !== exp_flags) begin
      errors++;
      $display("FAIL random_flags: %b required %b", {o_flag_inv, o_flag_unf, o_flag_ovf}, exp_flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] held;
    int           guard;
    start_test();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          drive_op({1'b0, EXP_W'($urandom_range(12, 17)), MAN_W'($urandom_range(0, (1 << MAN_W) - 1))},
                   {1'($urandom_range(0, 1)), EXP_W'($urandom_range(12, 17)),
                    MAN_W'($urandom_range(0, (1 << MAN_W) - 1))});
        end
      end
      begin
        guard = 0;
        do begin
          @(posedge i_clk); #1;
          guard++;
        end while (o_valid !== 1'b1 && guard < 50);
        i_ready = 1'b0;
        held = o_res;
        repeat (4) begin
          @(negedge i_clk);
          checks++;
          if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_res !== held) begin
            errors++;
            $display("FAIL stall: ready=%b valid=%b res=%h required 0 1 %h", o_ready, o_valid, o_res, held);
          end
          @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
      end
    join
    wait_drain(6);
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_res[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flags_clr();
    int guard;
    start_test();
    clr_flags();
    i_ready = 1'b0;
    drive_op(16'h7BFF, 16'h4000);
    guard = 0;
    while (o_valid !== 1'b1 && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    checks++;
    if (o_flag_ovf !== 1'b0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_before_xfer: ovf=%b valid=%b required 0 1", o_flag_ovf, o_valid);
    end
    i_ready = 1'b1;
    i_flags_clr = 1'b1;
    @(posedge i_clk); #1;
    i_flags_clr = 1'b0;
    checks++;
    if (o_flag_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b required 1", o_flag_ovf);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h7C00) begin
      errors++;
      $display("FAIL ovf_res: count %0d res %h required 1 7c00", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : '0);
    end
    clr_flags();
    checks++;
    if (o_flag_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b required 0", o_flag_ovf);
    end
  endtask

  task automatic test_reset_inflight();
    start_test();
    drive_op(16'h3C00, 16'h4000);
    drive_op(16'h4000, 16'h4000);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_res !== '0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_inflight: valid=%b res=%h ready=%b required 0 0000 1", o_valid, o_res, o_ready);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (8) @(posedge i_clk);
    #1;
    checks++;
    if (got_q.size() != 0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_stale: results %0d valid=%b required 0 0", got_q.size(), o_valid);
    end
    start_test();
    drive_op(16'h4000, 16'h4000);
    wait_drain(1);
    checks++;
    if (got_q.size() < 1 || got_q[0] !== 16'h4400) begin
      errors++;
      $display("FAIL rst_recover: got %h required 4400", (got_q.size() > 0) ? got_q[0] : '0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    exp_flags   = 3'b000;
    i_rst_n     = 1'b1;
    i_valid     = 1'b0;
    i_a         = '0;
    i_b         = '0;
    i_ready     = 1'b1;
    i_flags_clr = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_flags_clr();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
